bus_arbiter: RTL



---
 rtl/bus_arbiter_pkg.sv | 26 ++
 rtl/bus_arbiter_rr_pick.sv | 46 ++++
 rtl/bus_arbiter.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// bus_arbiter_pkg
//   Shared definitions for the system-bus arbiter:
//     - state_e       : arbiter FSM states (IDLE / BUSY / RESP)
//     - DEF_*         : default parameter values for bus_arbiter
//     - ptr_width()   : width of the round-robin pointer / winner index
// -----------------------------------------------------------------------------
package bus_arbiter_pkg;

    localparam int DEF_NUM_MASTERS    = 2;
    localparam int DEF_ADDR_WIDTH     = 32;
    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_TIMEOUT_CYCLES = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    // Index width for NumMasters requesters; never below one bit.
    function automatic int ptr_width(input int num_masters);
        return (num_masters > 1) ? $clog2(num_masters) : 1;
    endfunction

endpackage : bus_arbiter_pkg

// File: rtl/bus_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin picker: selects the first requester at or after
//   the pointer, wrapping modulo N.
//   Ports:
//     i_req   [N-1:0]   request vector
//     i_ptr   [PW-1:0]  highest-priority index (must be < N)
//     o_gnt   [N-1:0]   one-hot winner, zero when nothing requests
//     o_idx   [PW-1:0]  winner index
//     o_valid           a winner exists
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [PW-1:0] o_idx,
    output logic          o_valid
);

    int unsigned w_cand;

    // NOTE: every signal written here gets a default first, so no path through
    // the block leaves it unassigned and no latch is inferred.
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_cand  = 0;
        for (int i = 0; i < N; i++) begin
            // Candidate index ptr+i folded back into 0..N-1.
            w_cand = int'(i_ptr) + i;
            if (w_cand >= N) begin
                w_cand = w_cand - N;
            end
            if (!o_valid && i_req[w_cand]) begin
                o_valid       = 1'b1;
                o_gnt[w_cand] = 1'b1;
                o_idx         = PW'(w_cand);
            end
        end
    end

endmodule : rr_pick

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//   Round-robin arbiter sharing one system-bus slave path between NumMasters
//   requesters (master 0: core memory interface, master 1: debug SBA).
//   At most one transaction outstanding; request fields are latched at grant
//   and driven as registered bus outputs; the slave response is routed to the
//   granted master only.
//
//   Ports:
//     clk, rst_n        clock, asynchronous active-low reset
//     m_rd / m_wr       per-master read / write request levels
//     m_addr/wdata/be   per-master request fields
//     m_rdata           shared read data, valid with the matching m_done bit
//     m_done / m_fault  one-cycle completion / fault pulse to granted master
//     s_rd/s_wr/s_addr/s_wdata/s_be   registered bus request
//     s_rdata/s_done/s_fault          bus response
//     grant             one-hot current owner, zero when idle
//
//   Optional feature (macro BUS_ARBITER_TIMEOUT_EN): a wait-state counter
//   forces a fault after TimeoutCycles BUSY cycles without a bus response.
//   Without the macro BUSY waits indefinitely.
// -----------------------------------------------------------------------------
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int NumMasters    = DEF_NUM_MASTERS,
    parameter int AddrWidth     = DEF_ADDR_WIDTH,
    parameter int DataWidth     = DEF_DATA_WIDTH,
    parameter int TimeoutCycles = DEF_TIMEOUT_CYCLES
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NumMasters-1:0]                 m_rd,
    input  logic [NumMasters-1:0]                 m_wr,
    input  logic [NumMasters-1:0][AddrWidth-1:0]  m_addr,
    input  logic [NumMasters-1:0][DataWidth-1:0]  m_wdata,
    input  logic [NumMasters-1:0][DataWidth/8-1:0] m_be,
    output logic [DataWidth-1:0]                  m_rdata,
    output logic [NumMasters-1:0]                 m_done,
    output logic [NumMasters-1:0]                 m_fault,
    output logic                                  s_rd,
    output logic                                  s_wr,
    output logic [AddrWidth-1:0]                  s_addr,
    output logic [DataWidth-1:0]                  s_wdata,
    output logic [DataWidth/8-1:0]                s_be,
    input  logic [DataWidth-1:0]                  s_rdata,
    input  logic                                  s_done,
    input  logic                                  s_fault,
    output logic [NumMasters-1:0]                 grant
);

    localparam int PW = ptr_width(NumMasters);
    localparam int BW = DataWidth / 8;

    if (NumMasters < 2 || TimeoutCycles < 1) begin : g_param_check
        $error("bus_arbiter: NumMasters must be >= 2 and TimeoutCycles >= 1");
    end

    // ---------------------------------------------------------------- state
    state_e                r_state;
    state_e                w_state_nxt;
    logic [PW-1:0]         r_ptr;
    logic                  r_s_rd;
    logic                  r_s_wr;
    logic [AddrWidth-1:0]  r_s_addr;
    logic [DataWidth-1:0]  r_s_wdata;
    logic [BW-1:0]         r_s_be;
    logic [NumMasters-1:0] r_grant;
    logic                  r_illegal;

    logic [NumMasters-1:0] w_pick_gnt;
    logic [PW-1:0]         w_pick_idx;
    logic                  w_pick_valid;
    logic                  w_rd_sel;
    logic                  w_wr_sel;
    logic                  w_load;
    logic                  w_complete;
    logic                  w_timeout;

    // ---------------------------------------------------------------- picker
    rr_pick #(
        .N  (NumMasters),
        .PW (PW)
    ) u_rr_pick (
        .i_req   (m_rd | m_wr),
        .i_ptr   (r_ptr),
        .o_gnt   (w_pick_gnt),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    assign w_rd_sel = m_rd[w_pick_idx];
    assign w_wr_sel = m_wr[w_pick_idx];

    // ---------------------------------------------------------------- timeout
`ifdef BUS_ARBITER_TIMEOUT_EN
    localparam int TW = $clog2(TimeoutCycles + 1);

    logic [TW-1:0] r_timer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer <= '0;
        end else if (w_load) begin
            r_timer <= '0;
        end else if (r_state == BUSY && !w_complete) begin
            r_timer <= r_timer + 1'b1;
        end
    end

    assign w_timeout = (r_timer == TW'(TimeoutCycles));
`else
    assign w_timeout = 1'b0;
`endif

    // ---------------------------------------------------------------- FSM
    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Response pulses are combinational from the slave so the master sees
    // them in the same cycle the bus completes.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_complete  = 1'b0;
        m_done      = '0;
        m_fault     = '0;
        m_rdata     = '0;
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                // Fault wins over done; an illegal rd+wr request never reaches
                // the bus and is faulted in its first BUSY cycle.
                if (r_illegal || s_fault || w_timeout) begin
                    m_fault    = r_grant;
                    w_complete = 1'b1;
                end else if (s_done) begin
                    m_done     = r_grant;
                    w_complete = 1'b1;
                end
                if (w_complete) begin
                    m_rdata     = s_rdata;
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                // Dead cycle: lets the master drop its request before the
                // next arbitration.
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr     <= '0;
            r_s_rd    <= 1'b0;
            r_s_wr    <= 1'b0;
            r_s_addr  <= '0;
            r_s_wdata <= '0;
            r_s_be    <= '0;
            r_grant   <= '0;
            r_illegal <= 1'b0;
        end else if (w_load) begin
            r_s_addr  <= m_addr[w_pick_idx];
            r_s_wdata <= m_wdata[w_pick_idx];
            r_s_be    <= m_be[w_pick_idx];
            r_s_rd    <= w_rd_sel & ~w_wr_sel;
            r_s_wr    <= w_wr_sel & ~w_rd_sel;
            r_illegal <= w_rd_sel & w_wr_sel;
            r_grant   <= w_pick_gnt;
            r_ptr     <= (w_pick_idx == PW'(NumMasters - 1)) ? '0
                                                             : w_pick_idx + PW'(1);
        end else if (w_complete) begin
            // Address/data stay as latched; only the strobes and ownership drop.
            r_s_rd    <= 1'b0;
            r_s_wr    <= 1'b0;
            r_grant   <= '0;
            r_illegal <= 1'b0;
        end
    end

    assign s_rd    = r_s_rd;
    assign s_wr    = r_s_wr;
    assign s_addr  = r_s_addr;
    assign s_wdata = r_s_wdata;
    assign s_be    = r_s_be;
    assign grant   = r_grant;

endmodule : bus_arbiter
